// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
// Generates stage load enables, bubble flushes and EX operand forwarding
// selects, tracks data-memory waits with a timeout fault FSM, and keeps
// saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic        ex_regwen,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic        ma_regwen,
  input  logic [4:0]  ma_rd,
  input  logic        ma_mem_req,
  input  logic        dmem_ready,
  input  logic        wb_regwen,
  input  logic [4:0]  wb_rd,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exma_en,
  output logic        mawb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    ERR     = 2'b10
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic [7:0] nxt_wait;
  logic       mstall;
  logic       ldhaz;

  // Memory stall and load-use hazard terms; x0 never creates a dependency.
  assign mstall = ma_mem_req & ~dmem_ready;
  assign ldhaz  = ex_is_load & ex_regwen & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) |
                   (id_use_rs2 & (id_rs2 == ex_rd)));

  assign state       = cur_state;
  assign mem_timeout = (cur_state == ERR);

  // Forward source for one EX operand: the younger MA result wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ma_regwen && (ma_rd != 5'd0) && (ma_rd == rs))
      return 2'b10;
    else if (wb_regwen && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1);
  assign fwd_b = fwd_sel(ex_rs2);

  // State and wait counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= RUN;
      wait_cnt  <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= nxt_wait;
    end
  end

  // Next state: count consecutive stalled edges, fault when TIMEOUT is reached.
  always_comb begin
    nxt_state = cur_state;
    nxt_wait  = wait_cnt;
    case (cur_state)
      RUN: begin
        nxt_wait = 8'd0;
        if (mstall) begin
          if (TIMEOUT == 8'd1) begin
            nxt_state = ERR;
            nxt_wait  = 8'd1;
          end else begin
            nxt_state = MEMWAIT;
            nxt_wait  = 8'd1;
          end
        end
      end
      MEMWAIT: begin
        if (!mstall) begin
          nxt_state = RUN;
          nxt_wait  = 8'd0;
        end else if ((wait_cnt + 8'd1) == TIMEOUT) begin
          nxt_state = ERR;
          nxt_wait  = TIMEOUT;
        end else begin
          nxt_wait = wait_cnt + 8'd1;
        end
      end
      ERR: begin
        nxt_state = ERR;
      end
      default: begin
        nxt_state = RUN;
        nxt_wait  = 8'd0;
      end
    endcase
  end

  // Pipeline control decode, priority ERR > mstall > branch > load-use > normal.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exma_en    = 1'b1;
    mawb_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (cur_state == ERR || mstall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
      exma_en = 1'b0;
      mawb_en = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ldhaz) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Saturating performance counters for frozen-PC cycles and front-end flushes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_en && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven, hand-sequenced and randomized checks of
// hazard_ctrl against a behavioural model (TIMEOUT = 4).
module tb_hazard_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic       ex_regwen;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_br_taken;
    logic       ma_regwen;
    logic [4:0] ma_rd;
    logic       ma_mem_req;
    logic       dmem_ready;
    logic       wb_regwen;
    logic [4:0] wb_rd;
  } in_t;

  // ctl = {pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush}
  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  in_t         cur;
  logic        pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush;
  logic [1:0]  fwd_a, fwd_b, state;
  logic        mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int          tests = 0;
  int          fails = 0;

  // Model state: consecutive stalled edges, fault flag, counters.
  int          consec;
  bit          err;
  logic [31:0] scnt, fcnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
    .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2),
    .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2),
    .ex_regwen(cur.ex_regwen), .ex_rd(cur.ex_rd), .ex_is_load(cur.ex_is_load),
    .ex_br_taken(cur.ex_br_taken),
    .ma_regwen(cur.ma_regwen), .ma_rd(cur.ma_rd),
    .ma_mem_req(cur.ma_mem_req), .dmem_ready(cur.dmem_ready),
    .wb_regwen(cur.wb_regwen), .wb_rd(cur.wb_rd),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exma_en(exma_en),
    .mawb_en(mawb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t i);
    if (i.ma_regwen && i.ma_rd != 0 && i.ma_rd == rs) return 2'b10;
    if (i.wb_regwen && i.wb_rd != 0 && i.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t ref_comb(input in_t i, input bit e);
    out_t o;
    bit   mst, ldh;
    mst = i.ma_mem_req && !i.dmem_ready;
    ldh = i.ex_is_load && i.ex_regwen && i.ex_rd != 0 &&
          ((i.id_use_rs1 && i.id_rs1 == i.ex_rd) || (i.id_use_rs2 && i.id_rs2 == i.ex_rd));
    if (e || mst)            o.ctl = 7'b0000000;
    else if (i.ex_br_taken)  o.ctl = 7'b1111111;
    else if (ldh)            o.ctl = 7'b0011101;
    else                     o.ctl = 7'b1111100;
    o.fa = ref_fwd(i.ex_rs1, i);
    o.fb = ref_fwd(i.ex_rs2, i);
    return o;
  endfunction

  // Behavioural model advanced on every clock edge the DUT sees.
  always @(posedge clk or negedge reset_n) begin
    out_t mo;
    if (!reset_n) begin
      consec <= 0;
      err    <= 1'b0;
      scnt   <= 32'd0;
      fcnt   <= 32'd0;
    end else begin
      mo = ref_comb(cur, err);
      if (!mo.ctl[6] && scnt != 32'hFFFF_FFFF) scnt <= scnt + 1;
      if (mo.ctl[1] && fcnt != 32'hFFFF_FFFF) fcnt <= fcnt + 1;
      if (!err) begin
        if (cur.ma_mem_req && !cur.dmem_ready) begin
          consec <= consec + 1;
          if (consec + 1 >= TO) err <= 1'b1;
        end else begin
          consec <= 0;
        end
      end
    end
  end

  task automatic cmp(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic checkOutput(input string n);
    out_t e;
    e = ref_comb(cur, err);
    cmp({n, " ctl"}, {25'd0, pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush},
        {25'd0, e.ctl});
    cmp({n, " fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
    cmp({n, " fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
    cmp({n, " state"}, {30'd0, state}, err ? 32'd2 : (consec > 0 ? 32'd1 : 32'd0));
    cmp({n, " mem_timeout"}, {31'd0, mem_timeout}, {31'd0, err});
    cmp({n, " stall_cnt"}, stall_cnt, scnt);
    cmp({n, " flush_cnt"}, flush_cnt, fcnt);
  endtask

  // Drive a vector for one cycle and check it in the low clock phase.
  task automatic applyStimulus(input in_t i, input string n);
    cur = i;
    @(negedge clk);
    checkOutput(n);
  endtask

  // Asynchronous reset pulse between edges, checked before any edge occurs.
  task automatic resetPulse(input string n);
    #2 reset_n = 1'b0;
    #1;
    cmp({n, " async state"}, {30'd0, state}, 32'd0);
    cmp({n, " async stall_cnt"}, stall_cnt, 32'd0);
    cmp({n, " async flush_cnt"}, flush_cnt, 32'd0);
    cmp({n, " async mem_timeout"}, {31'd0, mem_timeout}, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input string n, input in_t i, input logic [6:0] c,
                              input logic [1:0] a, input logic [1:0] b);
    vec_t v;
    v.name = n; v.in = i; v.exp.ctl = c; v.exp.fa = a; v.exp.fb = b;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    in_t  base, t, lu;

    base = '0;
    base.dmem_ready = 1'b1;
    cur = base;

    // Combinational decode table, applied while reset is held low.
    vecs.push_back(mk("idle", base, 7'b1111100, 2'b00, 2'b00));
    lu = base; lu.ex_is_load = 1; lu.ex_regwen = 1; lu.ex_rd = 5; lu.id_rs1 = 5; lu.id_use_rs1 = 1;
    vecs.push_back(mk("loaduse_rs1", lu, 7'b0011101, 2'b00, 2'b00));
    t = lu; t.ex_rd = 0; t.id_rs1 = 0;
    vecs.push_back(mk("load_x0", t, 7'b1111100, 2'b00, 2'b00));
    t = lu; t.id_use_rs1 = 0;
    vecs.push_back(mk("load_unused", t, 7'b1111100, 2'b00, 2'b00));
    t = lu; t.ex_regwen = 0;
    vecs.push_back(mk("load_nowen", t, 7'b1111100, 2'b00, 2'b00));
    t = base; t.ex_is_load = 1; t.ex_regwen = 1; t.ex_rd = 9; t.id_rs2 = 9; t.id_use_rs2 = 1;
    vecs.push_back(mk("loaduse_rs2", t, 7'b0011101, 2'b00, 2'b00));
    t = lu; t.ex_br_taken = 1;
    vecs.push_back(mk("branch_haz", t, 7'b1111111, 2'b00, 2'b00));
    t = lu; t.ex_br_taken = 1; t.ma_mem_req = 1; t.dmem_ready = 0;
    vecs.push_back(mk("mstall_br", t, 7'b0000000, 2'b00, 2'b00));
    t = base; t.ma_mem_req = 1;
    vecs.push_back(mk("mem_ready", t, 7'b1111100, 2'b00, 2'b00));
    t = base; t.ma_rd = 7; t.wb_rd = 7; t.ex_rs2 = 7; t.ma_regwen = 1; t.wb_regwen = 1;
    vecs.push_back(mk("fwd_ma", t, 7'b1111100, 2'b00, 2'b10));
    t.ma_regwen = 0;
    vecs.push_back(mk("fwd_wb", t, 7'b1111100, 2'b00, 2'b01));
    t.ma_regwen = 1; t.ex_rs2 = 0;
    vecs.push_back(mk("fwd_rs0", t, 7'b1111100, 2'b00, 2'b00));
    t = base; t.ma_regwen = 1; t.wb_regwen = 1;
    vecs.push_back(mk("fwd_rd0", t, 7'b1111100, 2'b00, 2'b00));
    t = base; t.wb_regwen = 1; t.wb_rd = 3; t.ex_rs1 = 3; t.ma_regwen = 1; t.ma_rd = 4;
    vecs.push_back(mk("fwd_a_wb", t, 7'b1111100, 2'b01, 2'b00));

    #2;
    foreach (vecs[k]) begin
      cur = vecs[k].in;
      #1;
      cmp({vecs[k].name, " tbl ctl"},
          {25'd0, pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush},
          {25'd0, vecs[k].exp.ctl});
      cmp({vecs[k].name, " tbl fwd_a"}, {30'd0, fwd_a}, {30'd0, vecs[k].exp.fa});
      cmp({vecs[k].name, " tbl fwd_b"}, {30'd0, fwd_b}, {30'd0, vecs[k].exp.fb});
      checkOutput({vecs[k].name, " in_reset"});
    end

    cur = base;
    @(negedge clk);
    reset_n = 1'b1;

    // Load-use stall lasts one cycle and counts one stall.
    applyStimulus(lu, "loaduse");
    applyStimulus(base, "after_loaduse");
    cmp("loaduse stall_cnt", stall_cnt, 32'd1);

    // Branch overriding a load-use hazard.
    t = lu; t.ex_br_taken = 1;
    applyStimulus(t, "branch_haz");
    applyStimulus(base, "after_branch");
    cmp("branch flush_cnt", flush_cnt, 32'd1);

    // Three-cycle memory wait, released by dmem_ready.
    t = base; t.ma_mem_req = 1; t.dmem_ready = 0;
    for (int k = 0; k < 3; k++) applyStimulus(t, "memwait");
    cmp("memwait state", {30'd0, state}, 32'd1);
    t.dmem_ready = 1;
    applyStimulus(t, "mem_release");
    cmp("release ctl", {25'd0, pc_en, ifid_en, idex_en, exma_en, mawb_en, ifid_flush, idex_flush},
        32'h7C);
    applyStimulus(base, "after_release");
    cmp("after_release state", {30'd0, state}, 32'd0);

    // Timeout: four stalled edges reach ERR, which holds with ready high.
    t = base; t.ma_mem_req = 1; t.dmem_ready = 0;
    for (int k = 0; k < 4; k++) applyStimulus(t, "timeout");
    cmp("err state", {30'd0, state}, 32'd2);
    cmp("err mem_timeout", {31'd0, mem_timeout}, 32'd1);
    t.dmem_ready = 1;
    for (int k = 0; k < 2; k++) applyStimulus(t, "err_hold");
    cmp("err hold state", {30'd0, state}, 32'd2);
    resetPulse("err_reset");
    checkOutput("post_err_reset");

    // Re-entering MEMWAIT after reset, then async reset mid-wait.
    t = base; t.ma_mem_req = 1; t.dmem_ready = 0;
    applyStimulus(t, "reenter");
    applyStimulus(t, "reenter2");
    cmp("reenter state", {30'd0, state}, 32'd1);
    resetPulse("memwait_reset");
    checkOutput("post_memwait_reset");

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        resetPulse("rand_reset");
      end else begin
        t.id_rs1      = 5'($urandom_range(0, 3));
        t.id_rs2      = 5'($urandom_range(0, 3));
        t.id_use_rs1  = 1'($urandom_range(0, 1));
        t.id_use_rs2  = 1'($urandom_range(0, 1));
        t.ex_rs1      = 5'($urandom_range(0, 3));
        t.ex_rs2      = 5'($urandom_range(0, 3));
        t.ex_regwen   = 1'($urandom_range(0, 1));
        t.ex_rd       = 5'($urandom_range(0, 3));
        t.ex_is_load  = 1'($urandom_range(0, 1));
        t.ex_br_taken = ($urandom_range(0, 5) == 0);
        t.ma_regwen   = 1'($urandom_range(0, 1));
        t.ma_rd       = 5'($urandom_range(0, 3));
        t.ma_mem_req  = ($urandom_range(0, 2) == 0);
        t.dmem_ready  = 1'($urandom_range(0, 1));
        t.wb_regwen   = 1'($urandom_range(0, 1));
        t.wb_rd       = 5'($urandom_range(0, 3));
        applyStimulus(t, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8'd255, gives the number of consecutive data-memory stall cycles before the block declares a fault; legal range 1..255.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 id_rs1, id_rs2  in  5 each  source register addresses of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  high when the ID instruction reads the corresponding source.
REQ-006 ex_rs1, ex_rs2  in  5 each  source register addresses of the instruction in EX.
REQ-007 ex_regwen, ex_rd, ex_is_load  in  1/5/1  EX-stage write enable, destination, and load flag.
REQ-008 ex_br_taken  in  1  a branch or jump in EX redirects the PC this cycle.
REQ-009 ma_regwen, ma_rd  in  1/5  MA-stage write enable and destination.
REQ-010 ma_mem_req, dmem_ready  in  1/1  MA-stage memory access request, and memory completion.
REQ-011 wb_regwen, wb_rd  in  1/5  WB-stage write enable and destination.
REQ-012 pc_en, ifid_en, idex_en, exma_en, mawb_en  out  1 each  pipeline register load enables.
REQ-013 ifid_flush, idex_flush  out  1 each  load a bubble into IF/ID or ID/EX on this edge.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand source select: 00 = register file, 10 = MA result, 01 = WB data.
REQ-015 state  out  2  FSM state: 00 RUN, 01 MEMWAIT, 10 ERR.
REQ-016 mem_timeout  out  1  sticky fault flag.
REQ-017 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-018 mstall = ma_mem_req & ~dmem_ready; it is a combinational term.
REQ-019 ldhaz = ex_is_load & ex_regwen & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-020 FSM transitions:
- RUN -> MEMWAIT when mstall.
- MEMWAIT -> RUN on the first cycle with ~mstall.
- MEMWAIT -> ERR when the edge would bring wait_cnt to TIMEOUT.
- ERR is terminal until reset.
REQ-021 wait_cnt is an internal 8-bit counter.
- Cleared in RUN.
- Set to 1 on the RUN->MEMWAIT edge.
- Incremented on each MEMWAIT edge with mstall.
- Result: state = ERR after exactly TIMEOUT consecutive stalled cycles.
REQ-022 Priority is ERR > mstall > ex_br_taken > ldhaz > normal.
REQ-023 ERR: all five enables are 0, both flushes are 0, and mem_timeout = 1.
REQ-024 mstall, in any non-ERR state: all five enables are 0 and both flushes are 0; a pending branch flush is deferred and fires in the release cycle, since ex_br_taken is held.
REQ-025 ex_br_taken with no mstall: all enables are 1 and ifid_flush = idex_flush = 1; this overrides ldhaz because the stalled instruction is wrong-path.
REQ-026 ldhaz with no mstall and no branch: pc_en = ifid_en = 0, idex_en = exma_en = mawb_en = 1, idex_flush = 1; the stall lasts exactly one cycle.
REQ-027 Normal operation: all enables are 1 and both flushes are 0.
REQ-028 Forwarding for fwd_a (fwd_b identical, using ex_rs2):
- 10 if ma_regwen & ma_rd != 0 & ma_rd == ex_rs1;
- else 01 if wb_regwen & wb_rd != 0 & wb_rd == ex_rs1;
- else 00.
- MA has priority when both match.
- Forwarding is purely combinational and is independent of stall state.
REQ-029 stall_cnt increments on each edge where pc_en == 0, including ERR cycles; it saturates at 32'hFFFF_FFFF.
REQ-030 flush_cnt increments on each edge where ifid_flush == 1; it saturates at 32'hFFFF_FFFF.
REQ-031 Register x0 never triggers a hazard or a forward.

Reset
REQ-032 When reset_n is low, the following are forced immediately, independent of clk:
- state = RUN, wait_cnt = 0;
- mem_timeout = 0;
- stall_cnt = 0, flush_cnt = 0.
REQ-033 Reset asserted in MEMWAIT or ERR returns the block to RUN with the counters cleared; the first post-reset cycle with mstall re-enters MEMWAIT with wait_cnt = 1.
REQ-034 Combinational outputs reflect RUN-state decode of the current inputs during reset.

Verification
REQ-035 Load-use: ex_is_load = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> for one cycle pc_en = ifid_en = 0, idex_flush = 1; stall_cnt goes 0 -> 1.
REQ-036 Branch with hazard: ex_br_taken = 1 together with the REQ-035 stimulus -> ifid_flush = idex_flush = 1, pc_en = 1; flush_cnt goes to 1.
REQ-037 Forwarding: ma_rd = wb_rd = ex_rs2 = 7, both regwen = 1 -> fwd_b = 10; with ma_regwen = 0 -> fwd_b = 01; with ex_rs2 = 0 -> fwd_b = 00.
REQ-038 Memory wait: ma_mem_req = 1, dmem_ready low for 3 cycles, then high -> all enables 0 for 3 cycles, state = MEMWAIT, and enables return to 1 in the ready cycle.
REQ-039 Timeout: TIMEOUT = 4, dmem_ready held 0 -> state = ERR and mem_timeout = 1 after the 4th stalled edge; both persist with ready = 1 until reset_n pulses low.
REQ-040 Async reset mid-MEMWAIT: reset_n low between clock edges -> state = 00 and stall_cnt = 0 immediately, with no clock edge required.
